// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register map and data width for the GPIO port controller
package gpio_pkg;

   localparam int GPIO_DATA_W = 8;
   localparam int GPIO_ADDR_W = 4;

   typedef logic [GPIO_DATA_W-1:0] gpio_byte_t;
   typedef logic [GPIO_ADDR_W-1:0] gpio_addr_t;

   localparam gpio_addr_t GPIO_ADDR_OUT      = 4'd0;
   localparam gpio_addr_t GPIO_ADDR_DIR      = 4'd1;
   localparam gpio_addr_t GPIO_ADDR_PU       = 4'd2;
   localparam gpio_addr_t GPIO_ADDR_PD       = 4'd3;
   localparam gpio_addr_t GPIO_ADDR_IN       = 4'd4;
   localparam gpio_addr_t GPIO_ADDR_IRQ_EN   = 4'd5;
   localparam gpio_addr_t GPIO_ADDR_RISE_SEL = 4'd6;
   localparam gpio_addr_t GPIO_ADDR_FALL_SEL = 4'd7;
   localparam gpio_addr_t GPIO_ADDR_IRQ_STAT = 4'd8;

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - two-flop pad synchronizer with history flop and edge detect
module gpio_sync_edge #(
   parameter int N_PINS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_PINS-1:0] y,
   output logic [N_PINS-1:0] sync,
   output logic [N_PINS-1:0] rise,
   output logic [N_PINS-1:0] fall
);

   logic [N_PINS-1:0] s1;
   logic [N_PINS-1:0] s2;
   logic [N_PINS-1:0] s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= y;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync = s2;
   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/gpio_port_ctrl.sv
// rtl/gpio_port_ctrl.sv - GPIO register bank, pad drive, pull arbitration and edge interrupts
module gpio_port_ctrl
   import gpio_pkg::*;
#(
   parameter int N_PINS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        addr,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic [N_PINS-1:0] pad_a,
   output logic [N_PINS-1:0] pad_oe,
   output logic [N_PINS-1:0] pad_pu,
   output logic [N_PINS-1:0] pad_pd,
   input  logic [N_PINS-1:0] pad_y,
   output logic              irq
);

   logic [N_PINS-1:0] out_q;
   logic [N_PINS-1:0] dir_q;
   logic [N_PINS-1:0] pu_q;
   logic [N_PINS-1:0] pd_q;
   logic [N_PINS-1:0] irq_en_q;
   logic [N_PINS-1:0] rise_sel_q;
   logic [N_PINS-1:0] fall_sel_q;
   logic [N_PINS-1:0] irq_stat_q;

   logic [N_PINS-1:0] in_sync;
   logic [N_PINS-1:0] in_rise;
   logic [N_PINS-1:0] in_fall;

   logic [N_PINS-1:0] wr_bits;
   logic [N_PINS-1:0] irq_set;
   logic [N_PINS-1:0] irq_clr;
   logic [N_PINS-1:0] rd_sel;
   gpio_byte_t        rd_mux;

   gpio_sync_edge #(
      .N_PINS (N_PINS)
   ) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .y    (pad_y),
      .sync (in_sync),
      .rise (in_rise),
      .fall (in_fall)
   );

   assign wr_bits = wr_data[N_PINS-1:0];
   assign irq_set = (in_rise & rise_sel_q) | (in_fall & fall_sel_q);
   assign irq_clr = (wr_en && (addr == GPIO_ADDR_IRQ_STAT)) ? wr_bits : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q      <= '0;
         dir_q      <= '0;
         pu_q       <= '0;
         pd_q       <= '0;
         irq_en_q   <= '0;
         rise_sel_q <= '0;
         fall_sel_q <= '0;
      end else if (wr_en) begin
         case (addr)
            GPIO_ADDR_OUT:      out_q      <= wr_bits;
            GPIO_ADDR_DIR:      dir_q      <= wr_bits;
            GPIO_ADDR_PU:       pu_q       <= wr_bits;
            GPIO_ADDR_PD:       pd_q       <= wr_bits;
            GPIO_ADDR_IRQ_EN:   irq_en_q   <= wr_bits;
            GPIO_ADDR_RISE_SEL: rise_sel_q <= wr_bits;
            GPIO_ADDR_FALL_SEL: fall_sel_q <= wr_bits;
            default: ;
         endcase
      end
   end

   // A new edge in the same cycle as a W1C keeps the bit set so no event is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_stat_q <= '0;
         irq        <= 1'b0;
      end else begin
         irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_set;
         irq        <= |(irq_stat_q & irq_en_q);
      end
   end

   always_comb begin
      rd_sel = '0;
      case (addr)
         GPIO_ADDR_OUT:      rd_sel = out_q;
         GPIO_ADDR_DIR:      rd_sel = dir_q;
         GPIO_ADDR_PU:       rd_sel = pu_q;
         GPIO_ADDR_PD:       rd_sel = pd_q;
         GPIO_ADDR_IN:       rd_sel = in_sync;
         GPIO_ADDR_IRQ_EN:   rd_sel = irq_en_q;
         GPIO_ADDR_RISE_SEL: rd_sel = rise_sel_q;
         GPIO_ADDR_FALL_SEL: rd_sel = fall_sel_q;
         GPIO_ADDR_IRQ_STAT: rd_sel = irq_stat_q;
         default:            rd_sel = '0;
      endcase
      rd_mux                = '0;
      rd_mux[N_PINS-1:0]    = rd_sel;
   end

   // Reads sample pre-edge state, so a same-cycle write is not yet visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= rd_mux;
         end
      end
   end

   assign pad_a  = out_q;
   assign pad_oe = dir_q;
   assign pad_pu = pu_q;
   assign pad_pd = pd_q & ~pu_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// tb/tb_gpio_port_ctrl.sv - self-checking bench for gpio_port_ctrl
module tb_gpio_port_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] addr = '0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [7:0] pad_a;
   logic [7:0] pad_oe;
   logic [7:0] pad_pu;
   logic [7:0] pad_pd;
   logic [7:0] pad_y;
   logic       irq;
   logic [7:0] ext = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Driven pins loop back their own output; undriven pins follow the external level.
   assign pad_y = (pad_oe & pad_a) | (~pad_oe & ext);

   gpio_port_ctrl #(.N_PINS(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .pad_a    (pad_a),
      .pad_oe   (pad_oe),
      .pad_pu   (pad_pu),
      .pad_pd   (pad_pd),
      .pad_y    (pad_y),
      .irq      (irq)
   );

   typedef struct {
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
      logic [7:0] exp_a;
      logic [7:0] exp_oe;
      logic [7:0] exp_pu;
      logic [7:0] exp_pd;
   } vec_t;

   vec_t tbl [11];

   // Reference model: register file by address, pad sample history oldest-first.
   logic [7:0] m_reg [16];
   logic [7:0] m_stat;
   logic [7:0] m_hist [$];
   logic [7:0] m_rd_data;
   logic       m_rd_valid;
   logic       m_irq;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a;
      wr_data = d;
      wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] a, output logic [7:0] d);
      @(negedge clk);
      addr = a;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      chk("rd_valid_pulse", rd_valid, 1'b1);
      d = rd_data;
      @(negedge clk);
      chk("rd_valid_single", rd_valid, 1'b0);
   endtask

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_stat = '0;
      m_hist = '{8'h00, 8'h00, 8'h00};
      m_rd_data = '0;
      m_rd_valid = 1'b0;
      m_irq = 1'b0;
   endtask

   task automatic m_step(input logic w, input logic r, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] e);
      logic [7:0] y_now, in_val, rise, fall, clr;
      logic       next_irq;
      y_now = (m_reg[1] & m_reg[0]) | (~m_reg[1] & e);
      in_val = m_hist[1];
      rise = m_hist[1] & ~m_hist[0];
      fall = ~m_hist[1] & m_hist[0];
      next_irq = |(m_stat & m_reg[5]);
      if (r) begin
         if (a == 4'd4) m_rd_data = in_val;
         else if (a == 4'd8) m_rd_data = m_stat;
         else if (a < 4'd8) m_rd_data = m_reg[a];
         else m_rd_data = 8'h00;
      end
      m_rd_valid = r;
      clr = (w && a == 4'd8) ? d : 8'h00;
      m_stat = (m_stat & ~clr) | (rise & m_reg[6]) | (fall & m_reg[7]);
      if (w && a < 4'd8 && a != 4'd4) m_reg[a] = d;
      m_hist.push_back(y_now);
      void'(m_hist.pop_front());
      m_irq = next_irq;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rv;
      int lat;

      tbl[0]  = '{4'd0,  8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
      tbl[1]  = '{4'd1,  8'h0F, 8'h0F, 8'hA5, 8'h0F, 8'h00, 8'h00};
      tbl[2]  = '{4'd2,  8'h03, 8'h03, 8'hA5, 8'h0F, 8'h03, 8'h00};
      tbl[3]  = '{4'd3,  8'h06, 8'h06, 8'hA5, 8'h0F, 8'h03, 8'h04};
      tbl[4]  = '{4'd9,  8'hFF, 8'h00, 8'hA5, 8'h0F, 8'h03, 8'h04};
      tbl[5]  = '{4'd15, 8'h5A, 8'h00, 8'hA5, 8'h0F, 8'h03, 8'h04};
      tbl[6]  = '{4'd5,  8'h3C, 8'h3C, 8'hA5, 8'h0F, 8'h03, 8'h04};
      tbl[7]  = '{4'd5,  8'h00, 8'h00, 8'hA5, 8'h0F, 8'h03, 8'h04};
      tbl[8]  = '{4'd4,  8'hFF, 8'h05, 8'hA5, 8'h0F, 8'h03, 8'h04};
      tbl[9]  = '{4'd2,  8'h00, 8'h00, 8'hA5, 8'h0F, 8'h00, 8'h06};
      tbl[10] = '{4'd2,  8'h03, 8'h03, 8'hA5, 8'h0F, 8'h03, 8'h04};

      do_reset();
      chk("reset_pad_oe", pad_oe, 8'h00);
      chk("reset_pad_a", pad_a, 8'h00);
      chk("reset_pad_pu", pad_pu, 8'h00);
      chk("reset_pad_pd", pad_pd, 8'h00);
      chk("reset_irq", irq, 1'b0);
      chk("reset_rd_valid", rd_valid, 1'b0);
      for (int a = 0; a < 16; a++) begin
         do_read(4'(a), rv);
         chk($sformatf("reset_read_%0d", a), rv, 8'h00);
      end

      for (int i = 0; i < 11; i++) begin
         do_write(tbl[i].addr, tbl[i].wdata);
         chk($sformatf("tbl%0d_pad_a", i), pad_a, tbl[i].exp_a);
         chk($sformatf("tbl%0d_pad_oe", i), pad_oe, tbl[i].exp_oe);
         chk($sformatf("tbl%0d_pad_pu", i), pad_pu, tbl[i].exp_pu);
         chk($sformatf("tbl%0d_pad_pd", i), pad_pd, tbl[i].exp_pd);
         do_read(tbl[i].addr, rv);
         chk($sformatf("tbl%0d_rd", i), rv, tbl[i].exp_rd);
      end

      // IN latency: a pad change is visible to a read issued two edges later.
      ext = 8'hA0;
      do_read(4'd4, rv);
      chk("in_latency_old", rv, 8'h05);
      do_read(4'd4, rv);
      chk("in_latency_new", rv, 8'hA5);

      // Rising-edge interrupt on pin 0 and W1C.
      do_write(4'd1, 8'h00);
      ext = 8'h00;
      repeat (4) @(negedge clk);
      do_write(4'd6, 8'h01);
      do_write(4'd5, 8'h01);
      chk("pre_rise_irq", irq, 1'b0);
      ext = 8'h01;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (irq && lat == 0) lat = c;
      end
      chk("rise_irq_latency", lat, 4);
      do_read(4'd8, rv);
      chk("rise_stat", rv, 8'h01);
      do_write(4'd8, 8'h01);
      chk("irq_before_clear_lands", irq, 1'b1);
      @(negedge clk);
      chk("irq_after_w1c", irq, 1'b0);

      // Falling-edge status on pin 7 with interrupt masked, then W1C collision.
      do_write(4'd5, 8'h00);
      do_write(4'd6, 8'h00);
      do_write(4'd7, 8'h80);
      ext = 8'h81;
      repeat (4) @(negedge clk);
      ext = 8'h01;
      repeat (4) @(negedge clk);
      do_read(4'd8, rv);
      chk("fall_stat", rv, 8'h80);
      chk("fall_irq_masked", irq, 1'b0);
      do_write(4'd8, 8'h80);
      do_read(4'd8, rv);
      chk("fall_stat_cleared", rv, 8'h00);
      ext = 8'h81;
      repeat (4) @(negedge clk);
      ext = 8'h01;
      @(negedge clk);
      @(negedge clk);
      addr = 4'd8;
      wr_data = 8'h80;
      wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      do_read(4'd8, rv);
      chk("set_beats_clear", rv, 8'h80);
      chk("collision_irq_masked", irq, 1'b0);

      // Reset arriving with a read pending.
      ext = 8'h00;
      repeat (4) @(negedge clk);
      @(negedge clk);
      addr = 4'd0;
      rd_en = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      rst = 1'b0;
      chk("rst_no_rd_valid", rd_valid, 1'b0);
      chk("rst_pad_a", pad_a, 8'h00);
      chk("rst_pad_pu", pad_pu, 8'h00);
      chk("rst_irq", irq, 1'b0);
      for (int a = 0; a < 16; a++) begin
         do_read(4'(a), rv);
         chk($sformatf("midrst_read_%0d", a), rv, 8'h00);
      end

      // Randomized traffic against the reference model.
      ext = 8'h00;
      do_reset();
      m_reset();
      for (int i = 0; i < 1500; i++) begin
         logic w, r;
         logic [3:0] a;
         logic [7:0] d;
         w = ($urandom_range(0, 9) < 4);
         r = ($urandom_range(0, 9) < 4);
         a = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
         d = 8'($urandom);
         if ($urandom_range(0, 3) == 0) ext = 8'($urandom);
         addr = a;
         wr_en = w;
         wr_data = d;
         rd_en = r;
         m_step(w, r, a, d, ext);
         @(negedge clk);
         chk("rnd_pad_a", pad_a, m_reg[0]);
         chk("rnd_pad_oe", pad_oe, m_reg[1]);
         chk("rnd_pad_pu", pad_pu, m_reg[2]);
         chk("rnd_pad_pd", pad_pd, m_reg[3] & ~m_reg[2]);
         chk("rnd_irq", irq, m_irq);
         chk("rnd_rd_valid", rd_valid, m_rd_valid);
         if (m_rd_valid) chk("rnd_rd_data", rd_data, m_rd_data);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
